// File: rtl/fv_bank_req_arbiter_if.sv
// Request/packet bundle between the Edge PEs, the FV bank request arbiter and
// the FV bank controllers. The master side drives PE requests and bank
// availability. The slave side (the arbiter) returns grants and bank packets.
interface fv_bank_req_arbiter_if #(
    parameter int unsigned NUM_PE    = 4,
    parameter int unsigned NUM_BANK  = 4,
    parameter int unsigned NODE_ID_W = 8,
    parameter int unsigned DATA_W    = 1
);
    localparam int unsigned PE_TAG_W = $clog2(NUM_PE);

    // PE request side
    logic [NUM_PE-1:0]           pe_req_valid;
    logic [NUM_PE-1:0]           pe_req_rd_wr;
    logic [NUM_PE*NODE_ID_W-1:0] pe_req_Node_id;
    logic [NUM_PE*DATA_W-1:0]    pe_req_data;
    logic [NUM_PE-1:0]           pe_req_wr_sos;
    logic [NUM_PE-1:0]           pe_req_wr_eos;
    logic [NUM_PE-1:0]           pe_req_ready;

    // Bank request side
    logic [NUM_BANK-1:0]           bank_available;
    logic [NUM_BANK-1:0]           bank_req_valid;
    logic [NUM_BANK*PE_TAG_W-1:0]  bank_req_PE_tag;
    logic [NUM_BANK-1:0]           bank_req_rd_wr;
    logic [NUM_BANK*NODE_ID_W-1:0] bank_req_Node_id;
    logic [NUM_BANK*DATA_W-1:0]    bank_req_data;
    logic [NUM_BANK-1:0]           bank_req_wr_sos;
    logic [NUM_BANK-1:0]           bank_req_wr_eos;
    logic [NUM_BANK-1:0]           bank_locked;

    modport master (
        output pe_req_valid, pe_req_rd_wr, pe_req_Node_id, pe_req_data,
               pe_req_wr_sos, pe_req_wr_eos, bank_available,
        input  pe_req_ready, bank_req_valid, bank_req_PE_tag, bank_req_rd_wr,
               bank_req_Node_id, bank_req_data, bank_req_wr_sos, bank_req_wr_eos,
               bank_locked
    );

    modport slave (
        input  pe_req_valid, pe_req_rd_wr, pe_req_Node_id, pe_req_data,
               pe_req_wr_sos, pe_req_wr_eos, bank_available,
        output pe_req_ready, bank_req_valid, bank_req_PE_tag, bank_req_rd_wr,
               bank_req_Node_id, bank_req_data, bank_req_wr_sos, bank_req_wr_eos,
               bank_locked
    );
endinterface

// File: rtl/fv_bank_req_arbiter.sv
// FV bank request arbiter: routes PE request packets to FV banks selected by
// the low node-id bits. Each bank has its own round-robin arbiter and a
// write-stream lock that keeps the bank with one PE from sos to eos.
// Optional feature macro: FV_ARB_CONFLICT_CNT_EN adds per-bank 16-bit
// saturating conflict counters on output conflict_cnt.
module fv_bank_req_arbiter #(
    parameter int unsigned NUM_PE    = 4,
    parameter int unsigned NUM_BANK  = 4,
    parameter int unsigned NODE_ID_W = 8,
    parameter int unsigned DATA_W    = 1
) (
    input logic                  clk,
    input logic                  reset,
    fv_bank_req_arbiter_if.slave bus
`ifdef FV_ARB_CONFLICT_CNT_EN
    ,
    output logic [NUM_BANK*16-1:0] conflict_cnt
`endif
);
    localparam int unsigned PE_TAG_W = $clog2(NUM_PE);
    localparam int unsigned BANK_W   = $clog2(NUM_BANK);

    typedef enum logic {StIdle, StLocked} bank_state_e;

    bank_state_e         state_q [NUM_BANK];
    bank_state_e         state_d [NUM_BANK];
    logic [PE_TAG_W-1:0] owner_q [NUM_BANK];
    logic [PE_TAG_W-1:0] owner_d [NUM_BANK];
    logic [PE_TAG_W-1:0] rr_q    [NUM_BANK];
    logic [PE_TAG_W-1:0] rr_d    [NUM_BANK];

    logic [BANK_W-1:0]   tgt  [NUM_PE];
    logic [PE_TAG_W-1:0] win  [NUM_BANK];
    logic [NUM_BANK-1:0] hit;
    logic [NUM_BANK-1:0] grant;

    logic [NUM_BANK-1:0]           valid_q;
    logic [NUM_BANK*PE_TAG_W-1:0]  tag_q;
    logic [NUM_BANK-1:0]           rd_wr_q;
    logic [NUM_BANK*NODE_ID_W-1:0] node_id_q;
    logic [NUM_BANK*DATA_W-1:0]    data_q;
    logic [NUM_BANK-1:0]           sos_q;
    logic [NUM_BANK-1:0]           eos_q;

    // Target bank of each PE from the low node-id bits.
    always_comb begin
        for (int p = 0; p < NUM_PE; p++) begin
            tgt[p] = bus.pe_req_Node_id[p*NODE_ID_W +: BANK_W];
        end
    end

    // Per-bank round-robin pick: first candidate at or after rr_ptr; a locked
    // bank only considers its owner.
    always_comb begin : arb_comb
        logic [PE_TAG_W-1:0] idx;
        idx   = '0;
        hit   = '0;
        grant = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            win[b] = '0;
            for (int i = 0; i < NUM_PE; i++) begin
                idx = rr_q[b] + PE_TAG_W'(i);
                if (!hit[b] && bus.pe_req_valid[idx] && (tgt[idx] == BANK_W'(b)) &&
                    (state_q[b] == StIdle || owner_q[b] == idx)) begin
                    hit[b] = 1'b1;
                    win[b] = idx;
                end
            end
            grant[b] = hit[b] & bus.bank_available[b];
        end
    end

    // Each PE targets exactly one bank, so at most one grant lands per PE.
    always_comb begin
        bus.pe_req_ready = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (grant[b]) begin
                bus.pe_req_ready[win[b]] = 1'b1;
            end
        end
    end

    // Lock FSM and round-robin pointer next state.
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            state_d[b] = state_q[b];
            owner_d[b] = owner_q[b];
            rr_d[b]    = rr_q[b];
        end
        for (int b = 0; b < NUM_BANK; b++) begin
            unique case (state_q[b])
                StIdle: begin
                    if (grant[b]) begin
                        rr_d[b] = win[b] + PE_TAG_W'(1);
                        if (bus.pe_req_rd_wr[win[b]] && bus.pe_req_wr_sos[win[b]] &&
                            !bus.pe_req_wr_eos[win[b]]) begin
                            state_d[b] = StLocked;
                            owner_d[b] = win[b];
                        end
                    end
                end
                StLocked: begin
                    // Only the owner can win here; its eos write releases the bank.
                    if (grant[b] && bus.pe_req_rd_wr[win[b]] && bus.pe_req_wr_eos[win[b]]) begin
                        state_d[b] = StIdle;
                        rr_d[b]    = owner_q[b] + PE_TAG_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Lock FSM and round-robin pointer registers.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANK; b++) begin
            if (reset) begin
                state_q[b] <= StIdle;
                owner_q[b] <= '0;
                rr_q[b]    <= '0;
            end else begin
                state_q[b] <= state_d[b];
                owner_q[b] <= owner_d[b];
                rr_q[b]    <= rr_d[b];
            end
        end
    end

    // Registered bank packets; fields hold their value on ungranted cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            tag_q     <= '0;
            rd_wr_q   <= '0;
            node_id_q <= '0;
            data_q    <= '0;
            sos_q     <= '0;
            eos_q     <= '0;
        end else begin
            valid_q <= grant;
            for (int b = 0; b < NUM_BANK; b++) begin
                if (grant[b]) begin
                    tag_q[b*PE_TAG_W +: PE_TAG_W]    <= win[b];
                    rd_wr_q[b]                       <= bus.pe_req_rd_wr[win[b]];
                    node_id_q[b*NODE_ID_W +: NODE_ID_W] <=
                        bus.pe_req_Node_id[win[b]*NODE_ID_W +: NODE_ID_W];
                    data_q[b*DATA_W +: DATA_W]       <= bus.pe_req_data[win[b]*DATA_W +: DATA_W];
                    sos_q[b]                         <= bus.pe_req_wr_sos[win[b]];
                    eos_q[b]                         <= bus.pe_req_wr_eos[win[b]];
                end
            end
        end
    end

    // Drive the bank-side outputs from the registers.
    always_comb begin
        bus.bank_req_valid   = valid_q;
        bus.bank_req_PE_tag  = tag_q;
        bus.bank_req_rd_wr   = rd_wr_q;
        bus.bank_req_Node_id = node_id_q;
        bus.bank_req_data    = data_q;
        bus.bank_req_wr_sos  = sos_q;
        bus.bank_req_wr_eos  = eos_q;
        for (int b = 0; b < NUM_BANK; b++) begin
            bus.bank_locked[b] = (state_q[b] == StLocked);
        end
    end

`ifdef FV_ARB_CONFLICT_CNT_EN
    logic [NUM_BANK-1:0] conflict;
    logic [15:0]         cnt_q [NUM_BANK];

    // A bank is in conflict when two or more valid PEs target it, or when a
    // non-owner targets it while it is locked.
    always_comb begin : conflict_comb
        logic seen;
        seen     = 1'b0;
        conflict = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            seen = 1'b0;
            for (int p = 0; p < NUM_PE; p++) begin
                if (bus.pe_req_valid[p] && (tgt[p] == BANK_W'(b))) begin
                    if (seen) begin
                        conflict[b] = 1'b1;
                    end
                    seen = 1'b1;
                    if (state_q[b] == StLocked && owner_q[b] != PE_TAG_W'(p)) begin
                        conflict[b] = 1'b1;
                    end
                end
            end
        end
    end

    // Saturating per-bank conflict counters.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANK; b++) begin
            if (reset) begin
                cnt_q[b] <= '0;
            end else if (conflict[b] && cnt_q[b] != 16'hFFFF) begin
                cnt_q[b] <= cnt_q[b] + 16'd1;
            end
        end
    end

    // Flatten counters onto the output port.
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            conflict_cnt[b*16 +: 16] = cnt_q[b];
        end
    end
`endif

endmodule

// File: tb/tb_fv_bank_req_arbiter.sv
// Bench for fv_bank_req_arbiter: directed scenarios plus random traffic, all
// checked by a per-cycle scoreboard fed from a behavioural model.
module tb_fv_bank_req_arbiter;
    localparam int NP = 4;
    localparam int NB = 4;
    localparam int NW = 8;
    localparam int DW = 1;
    localparam int TW = 2;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fv_bank_req_arbiter_if #(.NUM_PE(NP), .NUM_BANK(NB), .NODE_ID_W(NW), .DATA_W(DW)) bus ();

`ifdef FV_ARB_CONFLICT_CNT_EN
    logic [NB*16-1:0] conflict_cnt;
`endif

    fv_bank_req_arbiter #(.NUM_PE(NP), .NUM_BANK(NB), .NODE_ID_W(NW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FV_ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    typedef struct packed {
        logic [NB-1:0]    vld;
        logic [NB-1:0]    lck;
        logic [NB-1:0]    rw;
        logic [NB-1:0]    sos;
        logic [NB-1:0]    eos;
        logic [NB*TW-1:0] tag;
        logic [NB*NW-1:0] nid;
        logic [NB*DW-1:0] dat;
        logic [NB*16-1:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    // Model state: owner < 0 means the bank is not locked.
    int        owner [NB];
    int        rr    [NB];
    int        ccnt  [NB];
    exp_t      mdl;
    logic [NP-1:0] last_rdy;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int target(input int p);
        return int'(bus.pe_req_Node_id[p*NW +: BW]);
    endfunction

    // One clock: evaluate the model on the current inputs, check grants,
    // queue the expected bank outputs for after the edge.
    task automatic step();
        logic [NP-1:0] rdy;
        int win, nreq;
        bit blocked;
        @(negedge clk);
        rdy = '0;
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                owner[b] = -1;
                rr[b] = 0;
                ccnt[b] = 0;
            end
            mdl = '0;
        end else begin
            mdl.vld = '0;
            for (int b = 0; b < NB; b++) begin
                win = -1;
                nreq = 0;
                blocked = 0;
                for (int p = 0; p < NP; p++) begin
                    if (bus.pe_req_valid[p] && target(p) == b) begin
                        nreq++;
                        if (owner[b] >= 0 && owner[b] != p) blocked = 1;
                    end
                end
                for (int i = 0; i < NP; i++) begin
                    int p;
                    p = (rr[b] + i) % NP;
                    if (win < 0 && bus.pe_req_valid[p] && target(p) == b &&
                        (owner[b] < 0 || owner[b] == p)) win = p;
                end
                if ((nreq >= 2 || blocked) && ccnt[b] < 65535) ccnt[b]++;
                if (win >= 0 && bus.bank_available[b]) begin
                    logic w, s, e;
                    w = bus.pe_req_rd_wr[win];
                    s = bus.pe_req_wr_sos[win];
                    e = bus.pe_req_wr_eos[win];
                    rdy[win] = 1'b1;
                    mdl.vld[b] = 1'b1;
                    mdl.tag[b*TW +: TW] = TW'(win);
                    mdl.rw[b] = w;
                    mdl.sos[b] = s;
                    mdl.eos[b] = e;
                    mdl.nid[b*NW +: NW] = bus.pe_req_Node_id[win*NW +: NW];
                    mdl.dat[b*DW +: DW] = bus.pe_req_data[win*DW +: DW];
                    if (owner[b] < 0) begin
                        rr[b] = (win + 1) % NP;
                        if (w && s && !e) owner[b] = win;
                    end else if (w && e) begin
                        owner[b] = -1;
                        rr[b] = (win + 1) % NP;
                    end
                end
            end
            for (int b = 0; b < NB; b++) begin
                mdl.lck[b] = (owner[b] >= 0);
                mdl.cnt[b*16 +: 16] = 16'(ccnt[b]);
            end
            check("pe_req_ready", 256'(bus.pe_req_ready), 256'(rdy));
        end
        last_rdy = rdy;
        expq.push_back(mdl);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        #3;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("bank_req_valid", 256'(bus.bank_req_valid), 256'(e.vld));
            check("bank_locked", 256'(bus.bank_locked), 256'(e.lck));
            check("bank_req_PE_tag", 256'(bus.bank_req_PE_tag), 256'(e.tag));
            check("bank_req_rd_wr", 256'(bus.bank_req_rd_wr), 256'(e.rw));
            check("bank_req_Node_id", 256'(bus.bank_req_Node_id), 256'(e.nid));
            check("bank_req_data", 256'(bus.bank_req_data), 256'(e.dat));
            check("bank_req_wr_sos", 256'(bus.bank_req_wr_sos), 256'(e.sos));
            check("bank_req_wr_eos", 256'(bus.bank_req_wr_eos), 256'(e.eos));
`ifdef FV_ARB_CONFLICT_CNT_EN
            check("conflict_cnt", 256'(conflict_cnt), 256'(e.cnt));
`endif
        end
    end

    task automatic drive(input int p, input logic rw, input int node, input logic d,
                         input logic s, input logic eo);
        bus.pe_req_valid[p] = 1'b1;
        bus.pe_req_rd_wr[p] = rw;
        bus.pe_req_Node_id[p*NW +: NW] = NW'(node);
        bus.pe_req_data[p] = d;
        bus.pe_req_wr_sos[p] = s;
        bus.pe_req_wr_eos[p] = eo;
    endtask

    task automatic idle();
        bus.pe_req_valid = '0;
        bus.pe_req_wr_sos = '0;
        bus.pe_req_wr_eos = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus.pe_req_valid = '0;
        bus.pe_req_rd_wr = '0;
        bus.pe_req_Node_id = '0;
        bus.pe_req_data = '0;
        bus.pe_req_wr_sos = '0;
        bus.pe_req_wr_eos = '0;
        bus.bank_available = '1;
        step();
        do_reset();

        // Four reads, one per bank.
        for (int p = 0; p < NP; p++) drive(p, 1'b0, p, 1'b0, 1'b0, 1'b0);
        step();
        check("all_banks_ready", 256'(last_rdy), 256'(4'hF));
        idle();
        step();

        // Three PEs contend for bank 0: grants rotate 0,1,2.
        do_reset();
        for (int p = 0; p < 3; p++) drive(p, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rr_order", 256'(last_rdy), 256'(1 << k));
        end
        idle();
        step();

        // PE1 write stream to bank 2 blocks PE3 until after eos.
        drive(1, 1'b1, 6, 1'b1, 1'b1, 1'b0);
        step();
        check("lock_taken", 256'(bus.bank_locked[2]), 256'(1'b1));
        drive(1, 1'b1, 6, 1'b0, 1'b0, 1'b0);
        drive(3, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        step();
        check("pe3_blocked_mid", 256'(last_rdy), 256'(4'b0010));
        check("lock_held", 256'(bus.bank_locked[2]), 256'(1'b1));
        drive(1, 1'b1, 6, 1'b1, 1'b0, 1'b1);
        step();
        check("pe3_blocked_eos", 256'(last_rdy), 256'(4'b0010));
        check("lock_released", 256'(bus.bank_locked[2]), 256'(1'b0));
        bus.pe_req_valid[1] = 1'b0;
        step();
        check("pe3_after_eos", 256'(last_rdy), 256'(4'b1000));
        idle();

        // Single-beat write does not lock.
        drive(2, 1'b1, 5, 1'b1, 1'b1, 1'b1);
        step();
        check("single_beat_ready", 256'(last_rdy), 256'(4'b0100));
        check("single_beat_nolock", 256'(bus.bank_locked[1]), 256'(1'b0));
        idle();

        // Bank 3 unavailable stalls PE0.
        bus.bank_available[3] = 1'b0;
        drive(0, 1'b0, 7, 1'b0, 1'b0, 1'b0);
        step();
        check("unavail_ready", 256'(last_rdy), 256'(4'b0000));
        check("unavail_valid", 256'(bus.bank_req_valid[3]), 256'(1'b0));
        bus.bank_available[3] = 1'b1;
        step();
        check("avail_ready", 256'(last_rdy), 256'(4'b0001));
        check("avail_valid", 256'(bus.bank_req_valid[3]), 256'(1'b1));
        idle();

        // Reset while bank 0 is locked by PE2; rr restarts at PE0.
        drive(2, 1'b1, 0, 1'b1, 1'b1, 1'b0);
        step();
        check("lock_before_reset", 256'(bus.bank_locked[0]), 256'(1'b1));
        drive(2, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("reset_unlock", 256'(bus.bank_locked), 256'(4'b0000));
        check("reset_valid", 256'(bus.bank_req_valid), 256'(4'b0000));
`ifdef FV_ARB_CONFLICT_CNT_EN
        check("reset_cnt", 256'(conflict_cnt), 256'(0));
`endif
        idle();
        drive(0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        drive(3, 1'b0, 4, 1'b0, 1'b0, 1'b0);
        step();
        check("post_reset_rr", 256'(last_rdy), 256'(4'b0001));
        idle();
        step();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            for (int p = 0; p < NP; p++) begin
                bus.pe_req_valid[p] = ($urandom_range(0, 9) < 6);
                bus.pe_req_rd_wr[p] = 1'($urandom_range(0, 1));
                bus.pe_req_Node_id[p*NW +: NW] = NW'($urandom);
                bus.pe_req_data[p] = 1'($urandom_range(0, 1));
                bus.pe_req_wr_sos[p] = ($urandom_range(0, 9) < 3);
                bus.pe_req_wr_eos[p] = ($urandom_range(0, 9) < 3);
            end
            for (int b = 0; b < NB; b++) bus.bank_available[b] = ($urandom_range(0, 19) < 17);
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;
        idle();
        bus.bank_available = '1;
        step();
        step();
        #5;
        check("scoreboard_drained", 256'(expq.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
